apb_rmw_master: RTL and testbench

Parametrised APB3 requester that accepts single commands over a valid/ready interface and runs READ, WRITE or atomic read-modify-write (fetch-and-add) transfers on the APB bus. It generalises the fixed-address increment master to any address, data width and addend. It adds slave-error capture, a wait-state timeout and a response channel. It sits between a local control engine and an APB interconnect.

---
 rtl/apb_pkg.sv | 9 +
 rtl/apb_wait_timer.sv | 24 ++
 rtl/apb_rmw_master.sv | 117 +++++++++++
 tb/tb_apb_rmw_master.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// apb_pkg: shared opcodes and state encodings for the APB read-modify-write master
package apb_pkg;
  typedef enum logic [1:0] {OP_NOP, OP_READ, OP_WRITE, OP_RMW} apb_op_t;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_state_t;
  localparam logic [1:0] OPC_NOP = 2'b00;
  localparam logic [1:0] OPC_READ = 2'b01;
  localparam logic [1:0] OPC_WRITE = 2'b10;
  localparam logic [1:0] OPC_RMW = 2'b11;
endpackage

// File: rtl/apb_wait_timer.sv
// apb_wait_timer: counts wait-state cycles and flags the last permitted one
module apb_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic pclk,
  input  logic preset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  if (TIMEOUT == 0) begin : g_off
    logic unused_in;
    assign unused_in = ^{pclk, preset_n, clr, en};
    assign expired = 1'b0;
  end else begin : g_on
    localparam int W = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    logic [W-1:0] cnt;
    always_ff @(posedge pclk or negedge preset_n)
      if (!preset_n) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (en) cnt <= cnt + W'(1);
    assign expired = en && cnt == W'(TIMEOUT - 1);
  end
endmodule

// File: rtl/apb_rmw_master.sv
// apb_rmw_master: APB3 requester running READ, WRITE and fetch-and-add transfers
module apb_rmw_master
  import apb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              preset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              psel_o,
  output logic              penable_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic              pwrite_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic [DATA_W-1:0] prdata_i,
  input  logic              pready_i,
  input  logic              pslverr_i
);
  apb_state_t state, nxt;
  apb_op_t op_q;
  logic [DATA_W-1:0] data_q, rdata_q;
  logic phase, err_q, to_q, live, expired, start;
  assign start = state == IDLE && live && cmd_valid && cmd_op != OPC_NOP;
  apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .pclk(pclk),
    .preset_n(preset_n),
    .clr(state == SETUP),
    .en(state == ACCESS && !pready_i),
    .expired(expired)
  );
  always_ff @(posedge pclk or negedge preset_n)
    if (!preset_n) begin
      state <= IDLE;
      live <= 1'b0;
    end else begin
      state <= nxt;
      live <= 1'b1;
    end
  always_comb begin
    nxt = state;
    cmd_ready = 1'b0;
    psel_o = 1'b0;
    penable_o = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_err = 1'b0;
    rsp_timeout = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = live;
        nxt = start ? SETUP : IDLE;
      end
      SETUP: begin
        psel_o = 1'b1;
        nxt = ACCESS;
      end
      ACCESS: begin
        psel_o = 1'b1;
        penable_o = 1'b1;
        nxt = pready_i ? ((!pslverr_i && op_q == OP_RMW && !phase) ? SETUP : RESP)
                       : (expired ? RESP : ACCESS);
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_rdata = rdata_q;
        rsp_err = err_q;
        rsp_timeout = to_q;
        nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge pclk or negedge preset_n)
    if (!preset_n) begin
      op_q <= OP_NOP;
      data_q <= '0;
      rdata_q <= '0;
      phase <= 1'b0;
      err_q <= 1'b0;
      to_q <= 1'b0;
      paddr_o <= '0;
      pwrite_o <= 1'b0;
      pwdata_o <= '0;
    end else if (start) begin
      op_q <= apb_op_t'(cmd_op);
      data_q <= cmd_data;
      rdata_q <= '0;
      phase <= 1'b0;
      err_q <= 1'b0;
      to_q <= 1'b0;
      paddr_o <= cmd_addr;
      pwrite_o <= cmd_op == OPC_WRITE;
      pwdata_o <= cmd_op == OPC_WRITE ? cmd_data : '0;
    end else if (state == ACCESS && nxt == SETUP) begin
      rdata_q <= prdata_i;
      phase <= 1'b1;
      pwrite_o <= 1'b1;
      pwdata_o <= prdata_i + data_q;
    end else if (state == ACCESS && nxt == RESP) begin
      rdata_q <= (pready_i && !pslverr_i && !pwrite_o) ? prdata_i : rdata_q;
      err_q <= !pready_i || pslverr_i;
      to_q <= !pready_i;
      paddr_o <= '0;
      pwrite_o <= 1'b0;
      pwdata_o <= '0;
    end
endmodule

// File: tb/tb_apb_rmw_master.sv
// tb_apb_rmw_master: directed scoreboard bench for the APB read-modify-write master
module tb_apb_rmw_master;
  import apb_pkg::*;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;
  logic pclk = 1'b0;
  logic preset_n = 1'b0;
  logic cmd_valid = 1'b0;
  logic [1:0] cmd_op = '0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_data = '0;
  logic cmd_ready, rsp_valid, rsp_err, rsp_timeout, psel_o, penable_o, pwrite_o;
  logic [DW-1:0] rsp_rdata, pwdata_o;
  logic [AW-1:0] paddr_o;
  logic [DW-1:0] prdata_i = '0;
  logic pready_i = 1'b0;
  logic pslverr_i = 1'b0;
  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;
  int t0 = 0;
  int s_waits = 0;
  int acnt = 0;
  bit s_never = 1'b0;
  bit s_err = 1'b0;
  logic [DW-1:0] s_rdata = '0;
  typedef struct {
    logic [DW-1:0] rdata;
    logic err;
    logic to;
    int t0;
    int lat;
  } exp_t;
  exp_t sb[$];
  apb_rmw_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .pclk(pclk),
    .preset_n(preset_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_addr(cmd_addr),
    .cmd_data(cmd_data),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .psel_o(psel_o),
    .penable_o(penable_o),
    .paddr_o(paddr_o),
    .pwrite_o(pwrite_o),
    .pwdata_o(pwdata_o),
    .prdata_i(prdata_i),
    .pready_i(pready_i),
    .pslverr_i(pslverr_i)
  );
  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;
  task automatic check(input string n, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", n, got, exp);
  endtask
  always @(negedge pclk) begin
    if (psel_o && penable_o) begin
      pready_i = !s_never && (acnt == s_waits);
      pslverr_i = pready_i && s_err;
      acnt++;
    end else begin
      pready_i = 1'b0;
      pslverr_i = 1'b0;
      acnt = 0;
    end
    prdata_i = s_rdata;
  end
  always @(negedge pclk) begin
    if (rsp_valid) begin
      exp_t e;
      check("rsp_expected", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", rsp_err, e.err);
        check("rsp_timeout", rsp_timeout, e.to);
        check("rsp_latency", cyc - e.t0, e.lat);
      end
    end
  end
  task automatic send(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge pclk);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_addr = a;
    cmd_data = d;
    for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge pclk);
    check("cmd_ready_at_issue", cmd_ready, 1);
    t0 = cyc;
    @(negedge pclk);
    cmd_valid = 1'b0;
    cmd_op = '0;
    cmd_addr = '0;
    cmd_data = '0;
  endtask
  task automatic expect_rsp(input logic [DW-1:0] rd, input logic err, input logic to, input int lat);
    exp_t e;
    e.rdata = rd;
    e.err = err;
    e.to = to;
    e.t0 = t0;
    e.lat = lat;
    sb.push_back(e);
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 40 && !cmd_ready; i++) @(negedge pclk);
    check("returned_idle", cmd_ready, 1);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    repeat (2) @(negedge pclk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_psel", psel_o, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_paddr", paddr_o, 0);
    preset_n = 1'b1;
    @(negedge pclk);
    check("idle_cmd_ready", cmd_ready, 1);
    s_waits = 0;
    s_rdata = 32'h1234_5678;
    send(OPC_READ, 32'h0000_A000, '0);
    expect_rsp(32'h1234_5678, 1'b0, 1'b0, 3);
    check("rd_c1_psel", psel_o, 1);
    check("rd_c1_penable", penable_o, 0);
    check("rd_paddr", paddr_o, 32'h0000_A000);
    check("rd_pwrite", pwrite_o, 0);
    @(negedge pclk);
    check("rd_c2_psel", psel_o, 1);
    check("rd_c2_penable", penable_o, 1);
    @(negedge pclk);
    check("rd_c3_psel", psel_o, 0);
    wait_idle();
    check("idle_paddr", paddr_o, 0);
    s_waits = 3;
    send(OPC_WRITE, 32'h10, 32'hDEAD_BEEF);
    expect_rsp('0, 1'b0, 1'b0, 6);
    check("wr_pwrite", pwrite_o, 1);
    for (int i = 0; i < 5; i++) begin
      check("wr_psel_held", psel_o, 1);
      check("wr_paddr_stable", paddr_o, 32'h10);
      check("wr_pwdata_stable", pwdata_o, 32'hDEAD_BEEF);
      @(negedge pclk);
    end
    wait_idle();
    s_waits = 0;
    s_rdata = 32'hFFFF_FFFF;
    send(OPC_RMW, 32'h0000_A000, 32'h1);
    expect_rsp(32'hFFFF_FFFF, 1'b0, 1'b0, 5);
    @(negedge pclk);
    check("rmw_rd_pwrite", pwrite_o, 0);
    @(negedge pclk);
    check("rmw_wr_psel", psel_o, 1);
    check("rmw_wr_penable", penable_o, 0);
    check("rmw_wr_pwrite", pwrite_o, 1);
    check("rmw_wr_pwdata_wrap", pwdata_o, 32'h0);
    check("rmw_wr_paddr", paddr_o, 32'h0000_A000);
    wait_idle();
    s_err = 1'b1;
    s_rdata = 32'h0000_0007;
    send(OPC_RMW, 32'h40, 32'h5);
    expect_rsp('0, 1'b1, 1'b0, 3);
    repeat (2) @(negedge pclk);
    check("rmw_err_c3_psel", psel_o, 0);
    @(negedge pclk);
    check("rmw_err_no_setup", psel_o, 0);
    wait_idle();
    s_err = 1'b0;
    s_never = 1'b1;
    send(OPC_READ, 32'h20, '0);
    expect_rsp('0, 1'b1, 1'b1, 6);
    repeat (4) @(negedge pclk);
    check("to_c5_psel", psel_o, 1);
    check("to_c5_penable", penable_o, 1);
    @(negedge pclk);
    check("to_c6_psel", psel_o, 0);
    check("to_c6_penable", penable_o, 0);
    wait_idle();
    s_never = 1'b0;
    s_waits = 3;
    s_rdata = 32'hCAFE_0001;
    send(OPC_READ, 32'h24, '0);
    expect_rsp(32'hCAFE_0001, 1'b0, 1'b0, 6);
    wait_idle();
    @(negedge pclk);
    cmd_valid = 1'b1;
    cmd_op = OPC_NOP;
    cmd_addr = 32'h50;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      check("nop_psel", psel_o, 0);
      check("nop_cmd_ready", cmd_ready, 1);
    end
    cmd_valid = 1'b0;
    s_never = 1'b1;
    send(OPC_READ, 32'h30, '0);
    @(negedge pclk);
    check("arst_in_access", penable_o, 1);
    preset_n = 1'b0;
    #1;
    check("arst_psel", psel_o, 0);
    check("arst_penable", penable_o, 0);
    check("arst_paddr", paddr_o, 0);
    check("arst_cmd_ready", cmd_ready, 0);
    check("arst_rsp_valid", rsp_valid, 0);
    repeat (2) @(negedge pclk);
    preset_n = 1'b1;
    s_never = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge pclk);
      check("post_rst_psel", psel_o, 0);
    end
    check("post_rst_cmd_ready", cmd_ready, 1);
    s_waits = 1;
    s_rdata = 32'h0000_55AA;
    send(OPC_READ, 32'h60, '0);
    expect_rsp(32'h0000_55AA, 1'b0, 1'b0, 4);
    wait_idle();
    repeat (3) @(negedge pclk);
    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
